// File: rtl/pipelined_csel_adder_if.sv
// Handshake and operand/result bundle for the pipelined carry-select adder.
interface pipelined_csel_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit carry-select block per
// stage, all stages advancing together under a single valid/ready enable.
module pipelined_csel_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_csel_adder_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / BLOCK;
  localparam int unsigned SW     = BLOCK + 1;

  logic             adv_c;
  logic [WIDTH-1:0] b_eff_c;
  logic             c_eff_c;

  assign adv_c   = !bus.out_valid || bus.out_ready;
  assign b_eff_c = bus.b ^ {WIDTH{bus.sub}};
  assign c_eff_c = bus.cin ^ bus.sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned IN   = WIDTH - k * BLOCK;
    localparam int unsigned DONE = (k + 1) * BLOCK;
    localparam int unsigned REM  = WIDTH - DONE;

    logic [IN-1:0]   a_src;
    logic [IN-1:0]   b_src;
    logic            c_src;
    logic            v_src;
    logic [DONE-1:0] res_d;
    logic [SW-1:0]   s0_c;
    logic [SW-1:0]   s1_c;
    logic [SW-1:0]   sel_c;
    logic            vld_q;
    logic            cry_q;
    logic [DONE-1:0] res_q;

    // Stage inputs: fresh operands at stage 0, otherwise the previous stage's registers.
    if (k == 0) begin : g_first
      assign a_src = bus.a;
      assign b_src = b_eff_c;
      assign c_src = c_eff_c;
      assign v_src = bus.in_valid;
      assign res_d = sel_c[BLOCK-1:0];
    end else begin : g_next
      assign a_src = g_stg[k-1].g_ops.a_q;
      assign b_src = g_stg[k-1].g_ops.b_q;
      assign c_src = g_stg[k-1].cry_q;
      assign v_src = g_stg[k-1].vld_q;
      assign res_d = {sel_c[BLOCK-1:0], g_stg[k-1].res_q};
    end

    // Both carry hypotheses computed in parallel; the incoming carry only drives the mux.
    assign s0_c  = {1'b0, a_src[BLOCK-1:0]} + {1'b0, b_src[BLOCK-1:0]};
    assign s1_c  = {1'b0, a_src[BLOCK-1:0]} + {1'b0, b_src[BLOCK-1:0]} + SW'(1);
    assign sel_c = c_src ? s1_c : s0_c;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cry_q <= 1'b0;
        res_q <= '0;
      end else if (adv_c) begin
        vld_q <= v_src;
        cry_q <= sel_c[BLOCK];
        res_q <= res_d;
      end
    end

    // Operand bits not yet consumed travel down with the partial result.
    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv_c) begin
          a_q <= a_src[IN-1:BLOCK];
          b_q <= b_src[IN-1:BLOCK];
        end
      end
    end

    // Carry into the MSB is recovered from sum ^ a ^ b of the top bit.
    if (k == STAGES - 1) begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv_c) begin
          ovf_q <= sel_c[BLOCK-1] ^ a_src[BLOCK-1] ^ b_src[BLOCK-1] ^ sel_c[BLOCK];
        end
      end
    end
  end

  assign bus.in_ready  = adv_c;
  assign bus.out_valid = g_stg[STAGES-1].vld_q;
  assign bus.sum       = g_stg[STAGES-1].res_q;
  assign bus.cout      = g_stg[STAGES-1].cry_q;
  assign bus.ovf       = g_stg[STAGES-1].g_last.ovf_q;
endmodule
